llsc_link_unit: RTL and testbench
=================================

// Module: llsc_link_unit
// PURPOSE
//  Responder side of the decoder's datomic qualifier: sits between datapath dmem port and dcache.
//  Holds the per-core link register for LL/SC, passes plain loads/stores straight through,
//  gates SC writes on link validity, returns SC result (1/0) as load data; clears link on snoop invalidate.
// PARAMETERS
//  ADDR_W    32  address width
//  WORD_W    32  data width
//  LINK_LSB  2   low address bits ignored for link match (2 = word granule, 3 = 2-word block)
// PORTS
//  CLK          in   1       clock, rising edge
//  nRST         in   1       reset, synchronous, active-low
//  dmemREN      in   1       datapath read request (held until dp_dhit)
//  dmemWEN      in   1       datapath write request (held until dp_dhit)
//  datomic      in   1       request is LL (with REN) or SC (with WEN)
//  dmemaddr     in   ADDR_W  request address
//  cache_dhit   in   1       dcache completes current ren/wen this cycle
//  cache_rdata  in   WORD_W  dcache load data
//  snoop_inv    in   1       coherence invalidate of a line this cycle
//  snoop_addr   in   ADDR_W  invalidated address
//  cache_ren    out  1       read request to dcache
//  cache_wen    out  1       write request to dcache (commits only on cache_dhit)
//  dp_dhit      out  1       completion to datapath
//  dp_rdata     out  WORD_W  load data / SC result to datapath
//  link_valid   out  1       link register valid (debug/verification)
// BEHAVIOUR
//  Reset: nRST low at CLK edge -> state IDLE, link_valid=0, link_addr=0; all outputs 0 while held.
//  match(a) = link_valid && a[ADDR_W-1:LINK_LSB]==link_addr.
//  States IDLE, SC_WAIT, SC_FAIL.
//  IDLE, non-SC request: combinational pass-through: cache_ren=dmemREN, cache_wen=dmemWEN&~datomic,
//   dp_dhit=cache_dhit, dp_rdata=cache_rdata.
//  IDLE, LL (REN&datomic): pass-through as read; on cache_dhit link_addr<=dmemaddr, link_valid<=1.
//  IDLE, plain SW: on cache_dhit && match(dmemaddr) -> link_valid<=0.
//  IDLE, SC (WEN&datomic): cache_wen=0, dp_dhit=0 this cycle; next state SC_WAIT if match, else SC_FAIL.
//  SC_WAIT: cache_wen=1, cache_ren=0. On cache_dhit: dp_dhit=1, dp_rdata=1, link_valid<=0, -> IDLE.
//  SC_FAIL: dp_dhit=1, dp_rdata=0, no cache access, -> IDLE (link_valid unchanged, already 0 or mismatch).
//  Latency: failed SC = 1 extra cycle; successful SC = 1 cycle + cache latency.
//  Snoop: snoop_inv && match(snoop_addr) -> link_valid<=0 next edge, in any state.
//  Snoop in SC_WAIT without cache_dhit same cycle -> abort: next state SC_FAIL, cache_wen drops; no write.
//  Snoop and cache_dhit same cycle in SC_WAIT -> write wins: result 1, link cleared.
//  LL cache_dhit and matching snoop same cycle -> snoop wins: link_valid ends 0.
//  New LL overwrites link_addr unconditionally (single link register).
//  Datapath must drop/advance request after dp_dhit; IDLE re-samples request every cycle.
//  REN and WEN both high: illegal; unit treats as write.
//  Reset mid-SC: state IDLE, link cleared, cache_wen low next cycle.
// TESTING
//  LL 0x100 (dhit@2) then SC 0x100 -> cache_wen 1 in SC_WAIT, dp_rdata=1, link_valid=0 after.
//  SC 0x200 with no prior LL -> cache_wen never high, dp_dhit 1 cycle later, dp_rdata=0.
//  LL 0x100, snoop_inv 0x104 (LINK_LSB=2) -> link kept; snoop_inv 0x100 -> SC returns 0.
//  LL 0x100, SC 0x100, snoop_inv 0x100 in SC_WAIT before dhit -> cache_wen drops, result 0.
//  Same as above with snoop and cache_dhit same cycle -> result 1, link_valid 0.
//  LL 0x100, plain SW 0x100 completes, SC 0x100 -> result 0; reset during SC_WAIT -> all outputs 0.

Source files
------------

// File: rtl/llsc_link_unit.sv
// rtl/llsc_link_unit.sv - LL/SC link register between datapath dmem port and dcache
// Plain accesses pass straight through; SC is gated on link validity and returns 1/0 as load data.
module llsc_link_unit #(
  parameter int ADDR_W   = 32,
  parameter int WORD_W   = 32,
  parameter int LINK_LSB = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic              datomic,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic              cache_dhit,
  input  logic [WORD_W-1:0] cache_rdata,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              cache_ren,
  output logic              cache_wen,
  output logic              dp_dhit,
  output logic [WORD_W-1:0] dp_rdata,
  output logic              link_valid
);

  localparam int TAG_W = ADDR_W - LINK_LSB;

  typedef enum logic [1:0] {IDLE, SC_WAIT, SC_FAIL} state_t;

  state_t             state_q, state_d;
  logic               link_valid_q, link_valid_d;
  logic [TAG_W-1:0]   link_addr_q, link_addr_d;

  logic [TAG_W-1:0]   req_tag, snoop_tag;
  logic               req_match, snoop_match;
  logic               is_write, is_sc, is_ll;
  logic               unused_lsb;

  assign req_tag     = dmemaddr[ADDR_W-1:LINK_LSB];
  assign snoop_tag   = snoop_addr[ADDR_W-1:LINK_LSB];
  assign unused_lsb  = ^{dmemaddr[LINK_LSB-1:0], snoop_addr[LINK_LSB-1:0]};
  assign req_match   = link_valid_q && (req_tag == link_addr_q);
  assign snoop_match = link_valid_q && (snoop_tag == link_addr_q);

  // REN and WEN together is treated as a write
  assign is_write = dmemWEN;
  assign is_sc    = dmemWEN & datomic;
  assign is_ll    = dmemREN & ~dmemWEN & datomic;

  always_comb begin
    state_d      = state_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    cache_ren    = 1'b0;
    cache_wen    = 1'b0;
    dp_dhit      = 1'b0;
    dp_rdata     = '0;

    case (state_q)
      IDLE: begin
        if (is_sc) begin
          state_d = req_match ? SC_WAIT : SC_FAIL;
        end else begin
          cache_ren = dmemREN & ~dmemWEN;
          cache_wen = is_write;
          dp_dhit   = cache_dhit;
          dp_rdata  = cache_rdata;
          if (is_ll && cache_dhit) begin
            link_addr_d  = req_tag;
            link_valid_d = 1'b1;
            // a snoop to the line being linked this same cycle must still kill the link
            if (snoop_inv && (snoop_tag == req_tag)) link_valid_d = 1'b0;
          end
          if (is_write && cache_dhit && req_match) link_valid_d = 1'b0;
        end
      end
      SC_WAIT: begin
        cache_wen = 1'b1;
        if (cache_dhit) begin
          dp_dhit      = 1'b1;
          dp_rdata     = WORD_W'(1);
          link_valid_d = 1'b0;
          state_d      = IDLE;
        end else if (snoop_inv && snoop_match) begin
          state_d = SC_FAIL;
        end
      end
      SC_FAIL: begin
        dp_dhit = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (snoop_inv && snoop_match) link_valid_d = 1'b0;

    link_valid = link_valid_q;

    if (!nRST) begin
      cache_ren  = 1'b0;
      cache_wen  = 1'b0;
      dp_dhit    = 1'b0;
      dp_rdata   = '0;
      link_valid = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

endmodule

// File: tb/tb_llsc_link_unit.sv
// tb/tb_llsc_link_unit.sv - self-checking bench for llsc_link_unit
// Pass-through vector table plus scoreboarded LL/SC sequences.
module tb_llsc_link_unit;

  logic        CLK, nRST;
  logic        dmemREN, dmemWEN, datomic, cache_dhit, snoop_inv;
  logic [31:0] dmemaddr, cache_rdata, snoop_addr;
  logic        cache_ren, cache_wen, dp_dhit, link_valid;
  logic [31:0] dp_rdata;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] sb[$];

  llsc_link_unit #(.ADDR_W(32), .WORD_W(32), .LINK_LSB(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic), .dmemaddr(dmemaddr),
    .cache_dhit(cache_dhit), .cache_rdata(cache_rdata),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .cache_ren(cache_ren), .cache_wen(cache_wen), .dp_dhit(dp_dhit),
    .dp_rdata(dp_rdata), .link_valid(link_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren, wen, at, dhit;
    logic [31:0] addr, rdata;
    logic        e_ren, e_wen, e_dhit;
    logic [31:0] e_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dmemREN = 0; dmemWEN = 0; datomic = 0; dmemaddr = 0;
    cache_dhit = 0; cache_rdata = 0; snoop_inv = 0; snoop_addr = 0;
  endtask

  task automatic do_ll(input logic [31:0] a, input int lat, input logic snoop_same, input logic exp_link);
    for (int k = 1; k <= lat; k++) begin
      @(negedge CLK);
      dmemREN = 1; datomic = 1; dmemaddr = a; cache_rdata = 32'hc0de_0000 + k;
      cache_dhit = (k == lat);
      snoop_inv = snoop_same && (k == lat); snoop_addr = a;
      #1;
      chk("ll_ren", cache_ren, 1);
      chk("ll_dhit", dp_dhit, (k == lat));
      if (k == lat) chk("ll_rdata", dp_rdata, 32'hc0de_0000 + k);
    end
    @(negedge CLK); idle_inputs(); #1;
    chk("ll_link", link_valid, exp_link);
  endtask

  task automatic do_sw(input logic [31:0] a, input logic exp_link);
    @(negedge CLK);
    dmemWEN = 1; dmemaddr = a; cache_dhit = 1;
    #1;
    chk("sw_wen", cache_wen, 1);
    chk("sw_dhit", dp_dhit, 1);
    @(negedge CLK); idle_inputs(); #1;
    chk("sw_link", link_valid, exp_link);
  endtask

  task automatic do_snoop(input logic [31:0] a, input logic exp_link);
    @(negedge CLK); snoop_inv = 1; snoop_addr = a;
    @(negedge CLK); idle_inputs(); #1;
    chk("snoop_link", link_valid, exp_link);
  endtask

  task automatic do_sc(input logic [31:0] a, input int lat, input int snoop_cyc,
                       input logic [31:0] exp_res, input logic exp_wen_seen,
                       input logic exp_link, output int done_cyc);
    logic        done, wen_seen;
    logic [31:0] exp;
    sb.push_back(exp_res);
    done = 0; wen_seen = 0; done_cyc = 0;
    @(negedge CLK);
    idle_inputs(); dmemWEN = 1; datomic = 1; dmemaddr = a;
    #1;
    chk("sc_issue_wen", cache_wen, 0);
    chk("sc_issue_dhit", dp_dhit, 0);
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge CLK);
      snoop_inv = (c == snoop_cyc); snoop_addr = a; cache_dhit = 0;
      #1;
      if (cache_wen) begin
        wen_seen = 1;
        cache_dhit = (c >= lat);
      end
      #1;
      if (dp_dhit) begin
        done = 1; done_cyc = c;
        exp = sb.pop_front();
        chk("sc_result", dp_rdata, exp);
        if (exp == 0) chk("sc_fail_wen", cache_wen, 0);
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL sc_timeout: got no dp_dhit expected dp_dhit within 8 cycles");
      if (sb.size() > 0) void'(sb.pop_front());
    end
    chk("sc_wen_seen", wen_seen, exp_wen_seen);
    @(negedge CLK); idle_inputs(); #1;
    chk("sc_link", link_valid, exp_link);
  endtask

  initial begin
    vec_t vecs[7];
    int   cyc;

    vecs[0] = '{1,0,0,0, 32'h40, 32'hdead_beef, 1,0,0, 32'hdead_beef};
    vecs[1] = '{1,0,0,1, 32'h40, 32'h1234_5678, 1,0,1, 32'h1234_5678};
    vecs[2] = '{0,1,0,0, 32'h80, 32'h0000_0011, 0,1,0, 32'h0000_0011};
    vecs[3] = '{0,1,0,1, 32'h80, 32'h0000_0022, 0,1,1, 32'h0000_0022};
    vecs[4] = '{1,1,0,0, 32'h84, 32'h0000_0033, 0,1,0, 32'h0000_0033};
    vecs[5] = '{1,0,1,0, 32'h88, 32'h0000_0044, 1,0,0, 32'h0000_0044};
    vecs[6] = '{0,0,0,1, 32'h00, 32'hffff_0000, 0,0,1, 32'hffff_0000};

    idle_inputs();
    nRST = 0;
    dmemREN = 1; cache_dhit = 1; cache_rdata = 32'h5a5a_5a5a;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ren", cache_ren, 0);
    chk("rst_wen", cache_wen, 0);
    chk("rst_dhit", dp_dhit, 0);
    chk("rst_rdata", dp_rdata, 0);
    chk("rst_link", link_valid, 0);
    @(negedge CLK); idle_inputs(); nRST = 1;

    foreach (vecs[i]) begin
      @(negedge CLK);
      dmemREN = vecs[i].ren; dmemWEN = vecs[i].wen; datomic = vecs[i].at;
      dmemaddr = vecs[i].addr; cache_dhit = vecs[i].dhit; cache_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d_ren", i), cache_ren, vecs[i].e_ren);
      chk($sformatf("vec%0d_wen", i), cache_wen, vecs[i].e_wen);
      chk($sformatf("vec%0d_dhit", i), dp_dhit, vecs[i].e_dhit);
      chk($sformatf("vec%0d_rdata", i), dp_rdata, vecs[i].e_rdata);
    end
    @(negedge CLK); idle_inputs(); #1;
    chk("vec_link", link_valid, 0);

    do_ll(32'h100, 2, 0, 1);
    do_sc(32'h100, 2, 0, 1, 1, 0, cyc);

    do_sc(32'h200, 1, 0, 0, 0, 0, cyc);
    chk("sc_fail_latency", cyc, 1);

    do_ll(32'h100, 1, 0, 1);
    do_snoop(32'h104, 1);
    do_snoop(32'h100, 0);
    do_sc(32'h100, 1, 0, 0, 0, 0, cyc);

    do_ll(32'h100, 1, 0, 1);
    do_sc(32'h100, 3, 1, 0, 1, 0, cyc);
    chk("sc_abort_latency", cyc, 2);

    do_ll(32'h100, 1, 0, 1);
    do_sc(32'h100, 1, 1, 1, 1, 0, cyc);

    do_ll(32'h100, 2, 0, 1);
    do_sw(32'h100, 0);
    do_sc(32'h100, 1, 0, 0, 0, 0, cyc);

    do_ll(32'h300, 1, 1, 0);

    do_ll(32'h100, 1, 0, 1);
    do_ll(32'h200, 1, 0, 1);
    do_sc(32'h100, 1, 0, 0, 0, 1, cyc);
    do_sc(32'h200, 1, 0, 1, 1, 0, cyc);

    do_ll(32'h100, 1, 0, 1);
    @(negedge CLK); dmemWEN = 1; datomic = 1; dmemaddr = 32'h100;
    @(negedge CLK); #1;
    chk("rstsc_wen_before", cache_wen, 1);
    nRST = 0; dmemREN = 1; cache_dhit = 1; cache_rdata = 32'hffff_ffff;
    #1;
    chk("rstsc_ren", cache_ren, 0);
    chk("rstsc_wen", cache_wen, 0);
    chk("rstsc_dhit", dp_dhit, 0);
    chk("rstsc_rdata", dp_rdata, 0);
    chk("rstsc_link", link_valid, 0);
    @(negedge CLK); idle_inputs(); nRST = 1; #1;
    chk("rstsc_wen_after", cache_wen, 0);
    chk("rstsc_link_after", link_valid, 0);
    do_sc(32'h100, 1, 0, 0, 0, 0, cyc);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
